mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Upstream controller for the 4:1 select mux (`D3..D0`, `S1/S0`, `Y`). It drives the mux select lines through the enabled channels one at a time, waits a settle interval on each, and samples the mux output `Y`. It packs the samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake. The mux sits between this block's `S1/S0` outputs and its `Y` input.

## Interface
One clock; reset is synchronous and active-high (`clk`, `rst`).

Parameters:
- `SETTLE`, default 2: cycles each select value is held before `Y` is sampled. Legal range is 1..15; 0 is illegal.
- `CONTINUOUS`, default 0: when 1, a new scan starts automatically after each accepted frame.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scan. Sampled only in IDLE.
- `chan_mask` in 4: bit k=1 enables channel Dk. Latched at scan start.
- `Y` in 1: mux output.
- `S1` out 1: mux select MSB.
- `S0` out 1: mux select LSB.
- `frame` out 4: bit k holds the sampled Dk, or 0 if channel k was disabled.
- `frame_valid` out 1: `frame` is valid.
- `frame_ready` in 1: downstream accepts the frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Channel-to-select mapping follows the mux decode: `{S1,S0}` = 3−k selects Dk.
  - D0 → 11
  - D1 → 10
  - D2 → 01
  - D3 → 00
- States: IDLE, SETTLE, OUTPUT.
- IDLE → start of scan, when `start`=1 at an edge:
  - latch `chan_mask` into `mask_q`
  - clear `frame` to 0
  - if `mask_q` ≠ 0: drive the select for the lowest enabled k, load the settle counter with `SETTLE`, go to SETTLE
  - if `mask_q` = 0: go directly to OUTPUT with `frame`=0
- SETTLE:
  - The counter decrements each cycle.
  - At the edge where it reaches 0, write `Y` into `frame[k]`.
  - If a higher enabled channel remains, drive its select at that same edge and reload the counter.
  - Otherwise go to OUTPUT.
- Channels are scanned in ascending k; disabled channels are skipped without any cycles spent on them.
- OUTPUT:
  - `frame_valid`=1 and `frame` is held stable until an edge with `frame_ready`=1.
  - At that edge, if `CONTINUOUS`=0 go to IDLE.
  - If `CONTINUOUS`=1, restart exactly as IDLE-with-`start`: re-latch `chan_mask`, clear `frame`.
- `start` is ignored outside IDLE. `chan_mask` changes after the latch edge have no effect on the current scan.
- `S1/S0` hold their last driven value in IDLE and OUTPUT.
- `rst` at any edge:
  - state → IDLE
  - `{S1,S0}`=00
  - `frame`=0, `frame_valid`=0, `busy`=0
  - settle counter=0, `mask_q`=0
  - any partial frame is discarded and no frame is emitted for it.
- `rst` has priority over `start` and `frame_ready`.

## Timing
- Reset values: `S1`=0, `S0`=0, `frame`=4'b0000, `frame_valid`=0, `busy`=0.
- Let E0 be the edge at which the scan starts (`start` seen in IDLE, or the handshake edge in continuous mode).
- The first select is visible after E0. `busy`=1 after E0.
- The i-th enabled channel (i=1..N) is sampled at edge E0+i·SETTLE. The select for channel i+1 is driven at that same edge.
- `frame_valid` rises after edge E0+N·SETTLE, with the complete frame valid in the same cycle.
  - With all four channels enabled and `SETTLE`=2, that is 8 cycles after E0.
- `mask_q`=0: `frame_valid` rises after E0, giving 1-cycle latency.
- Handshake:
  - The transfer occurs on an edge where `frame_valid`=1 and `frame_ready`=1.
  - `frame_valid` drops after that edge unless `CONTINUOUS`=1 and the restart's `mask_q`=0.
  - A `frame_ready` asserted while `frame_valid`=0 has no effect.
- `Y` is assumed stable within `SETTLE` cycles of a select change. The block registers `Y` directly with no extra synchronisation.

## Test plan
- Reset check: hold `rst` for 2 cycles with `start`=1 → `S1S0`=00, `frame`=0, `frame_valid`=0, `busy`=0. After release, `start` is accepted at the first edge.
- Full scan, `SETTLE`=2, `chan_mask`=1111, D3..D0=1,0,1,0 (mux responds combinationally), `frame_ready`=1 → selects 11,10,01,00 each held 2 cycles; `frame_valid` rises 8 cycles after the start edge with `frame`=4'b1010; `busy` low 1 cycle later.
- Partial mask, `chan_mask`=0101, all D=1 → only selects 11 and 01 appear; `frame`=4'b0101 after 4 cycles; `chan_mask` changed to 1111 mid-scan has no effect.
- Backpressure: `frame_ready`=0 for 5 cycles after `frame_valid` rises, with D toggling → `frame` and `S1S0` stay constant; the transfer happens on the 6th edge; a `start` pulse during the scan is ignored.
- Mask zero and continuous mode: `chan_mask`=0000 → `frame_valid` 1 cycle after start with `frame`=0. With `CONTINUOUS`=1 and mask 1000, back-to-back frames arrive every `SETTLE`+1 cycles when `frame_ready`=1.
- Reset mid-operation: assert `rst` 3 cycles into a full scan → all outputs return to reset values next edge, and no `frame_valid` follows; a subsequent `start` produces a correct fresh frame.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// Bundle of the scan sequencer's control, mux-select and frame handshake signals.
// The master side is the sequencer; the slave side is the mux/downstream environment.
interface mux_scan_sequencer_if;
    logic       start;
    logic [3:0] chan_mask;
    logic       Y;
    logic       S1;
    logic       S0;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;

    modport master (
        input  start, chan_mask, Y, frame_ready,
        output S1, S0, frame, frame_valid, busy
    );

    modport slave (
        output start, chan_mask, Y, frame_ready,
        input  S1, S0, frame, frame_valid, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through the enabled channels, samples Y after a settle
// interval on each, and hands the packed 4-bit frame downstream via valid/ready.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE     = 2,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.master  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] mask_q;
    logic [3:0] frame_q;
    logic [1:0] sel_q;
    logic [1:0] cur_k;
    logic [1:0] first_k;
    logic [1:0] next_k;
    logic       has_next;
    logic       launch;

    // Descending loops so the lowest qualifying channel is the one left standing.
    always_comb begin
        first_k = '0;
        for (int j = 3; j >= 0; j--) begin
            if (bus.chan_mask[j]) first_k = 2'(j);
        end
    end

    always_comb begin
        has_next = 1'b0;
        next_k   = cur_k;
        for (int j = 3; j >= 0; j--) begin
            if (j > int'(cur_k) && mask_q[j]) begin
                has_next = 1'b1;
                next_k   = 2'(j);
            end
        end
    end

    assign launch = (state == ST_IDLE && bus.start) ||
                    (state == ST_OUTPUT && bus.frame_ready && CONTINUOUS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            frame_q <= '0;
            cnt     <= '0;
            mask_q  <= '0;
            cur_k   <= '0;
        end else if (launch) begin
            mask_q  <= bus.chan_mask;
            frame_q <= '0;
            if (bus.chan_mask != '0) begin
                cur_k <= first_k;
                sel_q <= ~first_k;
                cnt   <= SETTLE_LD;
                state <= ST_SETTLE;
            end else begin
                state <= ST_OUTPUT;
            end
        end else begin
            case (state)
                ST_SETTLE: begin
                    // cnt==1 here means it reaches zero on this edge: sample now.
                    if (cnt == 4'd1) begin
                        frame_q[cur_k] <= bus.Y;
                        if (has_next) begin
                            cur_k <= next_k;
                            sel_q <= ~next_k;
                            cnt   <= SETTLE_LD;
                        end else begin
                            cnt   <= '0;
                            state <= ST_OUTPUT;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (bus.frame_ready) state <= ST_IDLE;
                end
                ST_IDLE: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.S1          = sel_q[1];
    assign bus.S0          = sel_q[0];
    assign bus.frame       = frame_q;
    assign bus.frame_valid = (state == ST_OUTPUT);
    assign bus.busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one one-shot and one continuous instance, each
// checked every cycle against a time-based model, plus directed literal checks.
module tb_mux_scan_sequencer;
    localparam int SETTLE  = 2;
    localparam int M_IDLE  = 0;
    localparam int M_SCAN  = 1;
    localparam int M_OUT   = 2;

    typedef struct packed {
        int         mode;
        int         e;
        logic [1:0] sel;
        logic [3:0] frame;
        logic [3:0] mask;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    int         vectors = 0;
    int         miscompares = 0;
    model_t     mdl = '0;
    model_t     mdlc = '0;

    mux_scan_sequencer_if bus ();
    mux_scan_sequencer_if busc ();

    mux_scan_sequencer #(.SETTLE(SETTLE), .CONTINUOUS(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    mux_scan_sequencer #(.SETTLE(SETTLE), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(busc.master)
    );

    // The 4:1 mux itself: select value 3-k routes Dk to Y.
    assign bus.Y  = d[~{bus.S1, bus.S0}];
    assign busc.Y = d[~{busc.S1, busc.S0}];

    always #5 clk = ~clk;

    function automatic int nth_chan(input logic [3:0] m, input int idx);
        int c = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                if (c == idx) return k;
                c++;
            end
        end
        return 0;
    endfunction

    // Model tracks elapsed cycles since scan start; channel i is sampled at i*SETTLE.
    function automatic model_t step(input model_t m, input logic r, input logic s,
                                    input logic [3:0] cm, input logic rdy,
                                    input logic [3:0] dv, input bit cont);
        model_t n = m;
        logic   y;
        int     idx;
        y = dv[3 - int'(m.sel)];
        if (r) begin
            n = '0;
            return n;
        end
        if ((m.mode == M_IDLE && s) || (m.mode == M_OUT && rdy && cont)) begin
            n.mask  = cm;
            n.frame = '0;
            n.e     = 0;
            if (cm == 4'b0) n.mode = M_OUT;
            else begin
                n.mode = M_SCAN;
                n.sel  = 2'(3 - nth_chan(cm, 0));
            end
        end else if (m.mode == M_OUT && rdy) begin
            n.mode = M_IDLE;
        end else if (m.mode == M_SCAN) begin
            n.e = m.e + 1;
            if (n.e % SETTLE == 0) begin
                idx = n.e / SETTLE;
                n.frame[nth_chan(m.mask, idx - 1)] = y;
                if (idx == $countones(m.mask)) n.mode = M_OUT;
                else n.sel = 2'(3 - nth_chan(m.mask, idx));
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] m, input logic r);
        bus.start       = s;
        bus.chan_mask   = m;
        bus.frame_ready = r;
    endtask

    task automatic waitValid(output int cyc, output logic [3:0] seen);
        cyc  = 0;
        seen = '0;
        while (!bus.frame_valid && cyc < 50) begin
            if (bus.busy) seen[{bus.S1, bus.S0}] = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!bus.frame_valid) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL valid_timeout: frame_valid=0 after %0d cycles, expected 1", cyc);
        end
    endtask

    always @(posedge clk) begin
        mdl  = step(mdl, rst, bus.start, bus.chan_mask, bus.frame_ready, d, 1'b0);
        mdlc = step(mdlc, rst, busc.start, busc.chan_mask, busc.frame_ready, d, 1'b1);
        #1;
        checkOutput("sel", {2'b0, bus.S1, bus.S0}, {2'b0, mdl.sel});
        checkOutput("busy", {3'b0, bus.busy}, {3'b0, mdl.mode != M_IDLE});
        checkOutput("valid", {3'b0, bus.frame_valid}, {3'b0, mdl.mode == M_OUT});
        if (mdl.mode == M_OUT) checkOutput("frame", bus.frame, mdl.frame);
        checkOutput("c_sel", {2'b0, busc.S1, busc.S0}, {2'b0, mdlc.sel});
        checkOutput("c_busy", {3'b0, busc.busy}, {3'b0, mdlc.mode != M_IDLE});
        checkOutput("c_valid", {3'b0, busc.frame_valid}, {3'b0, mdlc.mode == M_OUT});
        if (mdlc.mode == M_OUT) checkOutput("c_frame", busc.frame, mdlc.frame);
    end

    initial begin
        int         cyc;
        int         vhits;
        logic [3:0] seen;
        int         hits[$];

        rst = 1'b1;
        d   = 4'b1010;
        applyStimulus(1'b1, 4'b1111, 1'b1);
        busc.start = 1'b0; busc.chan_mask = 4'b0000; busc.frame_ready = 1'b0;

        // Reset held two edges with start high.
        repeat (2) @(negedge clk);
        checkOutput("rst_sel", {2'b0, bus.S1, bus.S0}, 4'b0000);
        checkOutput("rst_frame", bus.frame, 4'b0000);
        checkOutput("rst_valid", {3'b0, bus.frame_valid}, 4'b0000);
        checkOutput("rst_busy", {3'b0, bus.busy}, 4'b0000);
        rst = 1'b0;

        // Full scan D3..D0=1,0,1,0 starting on the first edge after reset.
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("start_busy", {3'b0, bus.busy}, 4'b0001);
        checkOutput("first_sel", {2'b0, bus.S1, bus.S0}, 4'b0011);
        waitValid(cyc, seen);
        checkOutput("full_latency", 4'(cyc), 4'd8);
        checkOutput("full_frame", bus.frame, 4'b1010);
        checkOutput("full_seen", seen, 4'b1111);
        @(negedge clk);
        checkOutput("full_busy_drop", {3'b0, bus.busy}, 4'b0000);
        checkOutput("full_valid_drop", {3'b0, bus.frame_valid}, 4'b0000);

        // Partial mask; mask widened after the latch edge must not matter.
        d = 4'b1111;
        applyStimulus(1'b1, 4'b0101, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        waitValid(cyc, seen);
        checkOutput("part_latency", 4'(cyc), 4'd4);
        checkOutput("part_frame", bus.frame, 4'b0101);
        checkOutput("part_seen", seen, 4'b1010);
        @(negedge clk);

        // Backpressure with a stray start pulse mid-scan.
        d = 4'b1010;
        applyStimulus(1'b1, 4'b1111, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitValid(cyc, seen);
        for (int i = 0; i < 5; i++) begin
            d = ~d;
            @(negedge clk);
            checkOutput("bp_valid", {3'b0, bus.frame_valid}, 4'b0001);
            checkOutput("bp_frame", bus.frame, 4'b1010);
            checkOutput("bp_sel", {2'b0, bus.S1, bus.S0}, 4'b0000);
        end
        bus.frame_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_xfer", {3'b0, bus.frame_valid}, 4'b0000);
        checkOutput("bp_idle", {3'b0, bus.busy}, 4'b0000);

        // Empty mask: frame_valid right after the start edge.
        d = 4'b1010;
        applyStimulus(1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        waitValid(cyc, seen);
        checkOutput("zero_latency", 4'(cyc), 4'd0);
        checkOutput("zero_frame", bus.frame, 4'b0000);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        checkOutput("zero_xfer", {3'b0, bus.frame_valid}, 4'b0000);

        // Reset three cycles into a full scan.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_busy", {3'b0, bus.busy}, 4'b0000);
        checkOutput("mid_rst_sel", {2'b0, bus.S1, bus.S0}, 4'b0000);
        checkOutput("mid_rst_frame", bus.frame, 4'b0000);
        vhits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.frame_valid) vhits++;
        end
        checkOutput("mid_rst_no_frame", 4'(vhits), 4'd0);
        d = 4'b0110;
        applyStimulus(1'b1, 4'b1111, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        waitValid(cyc, seen);
        checkOutput("fresh_latency", 4'(cyc), 4'd8);
        checkOutput("fresh_frame", bus.frame, 4'b0110);

        // Continuous instance, mask 1000: a frame every SETTLE+1 cycles.
        d = 4'b1000;
        busc.chan_mask = 4'b1000;
        busc.frame_ready = 1'b1;
        busc.start = 1'b1;
        @(negedge clk);
        busc.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (busc.frame_valid) begin
                hits.push_back(i);
                checkOutput("cont_frame", busc.frame, 4'b1000);
            end
            @(negedge clk);
        end
        checkOutput("cont_count", 4'(hits.size()), 4'd5);
        if (hits.size() > 0) checkOutput("cont_first", 4'(hits[0]), 4'd2);
        for (int k = 1; k < hits.size(); k++)
            checkOutput("cont_period", 4'(hits[k] - hits[k-1]), 4'd3);

        // Continuous restart with an empty mask keeps frame_valid high.
        busc.chan_mask = 4'b0000;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("cont_zero_valid", {3'b0, busc.frame_valid}, 4'b0001);
            checkOutput("cont_zero_frame", busc.frame, 4'b0000);
            @(negedge clk);
        end
        busc.frame_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
